// File: rtl/wb_freq_scan.sv
// Bus-mapped multi-channel frequency counter: counts synchronised edges per channel over a reference-edge gate.
// Optional interrupt output and CSR irq_en bit are enabled by defining WB_FREQ_SCAN_IRQ_EN.
module wb_freq_scan #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig_in,
  input  logic            ref_in,
  input  logic [3:0]      bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  input  logic            bus_cyc,
  output logic            bus_ack,
  input  logic            bus_we
`ifdef WB_FREQ_SCAN_IRQ_EN
  ,
  output logic            irq
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    GATE = 3'd2,
    DONE = 3'd3
  } state_t;

  state_t state, state_nxt;

  logic [N_CH:0]      sync_q [SYNC_STAGES];
  logic [N_CH:0]      sync_prev;
  logic [N_CH:0]      rise;
  logic               ref_rise;
  logic [N_CH-1:0]    sig_rise;

  logic               wr_stb;
  logic [3:0]         wr_addr;
  logic [31:0]        wr_data;
  logic               csr_wr, go_cmd, stop_cmd;
  logic [31:0]        rd_mux;

  logic               cont, done, busy, irq_en_rd;
  logic [CNT_W-1:0]   gate_len, gate_lim, gate_cnt, gate_cnt_inc, eff_len;
  logic [CNT_W-1:0]   edge_cnt [N_CH];
  logic [N_CH-1:0]    edge_ovf;
  logic [CNT_W-1:0]   res_cnt [N_CH];
  logic [N_CH-1:0]    res_ovf;
  logic               res_valid;
  logic               unused_wr_bits;

  // Reference rides along as the top bit so it sees exactly the same latency as the channels
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= {ref_in, sig_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign ref_rise = rise[N_CH];
  assign sig_rise = rise[N_CH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      bus_ack   <= bus_cyc & ~bus_ack;
      bus_rdata <= (bus_cyc & ~bus_ack) ? rd_mux : '0;
      wr_stb    <= bus_cyc & bus_we & ~bus_ack;
      if (bus_cyc & bus_we & ~bus_ack) begin
        wr_addr <= bus_addr;
        wr_data <= bus_wdata;
      end
    end
  end

  assign csr_wr         = wr_stb && (wr_addr == 4'h0);
  assign stop_cmd       = csr_wr & wr_data[30];
  assign go_cmd         = csr_wr & wr_data[31] & ~wr_data[30];
  assign busy           = (state != IDLE);
  assign unused_wr_bits = ^wr_data;
  assign gate_cnt_inc   = gate_cnt + CNT_W'(1);
  assign eff_len        = (gate_len == '0) ? CNT_W'(1) : gate_len;

  always_comb begin
    rd_mux = '0;
    if (bus_addr == 4'h0) begin
      rd_mux = {busy, 1'b0, cont, irq_en_rd, done, state, 24'b0};
    end else if (bus_addr == 4'h1) begin
      rd_mux = 32'(gate_len);
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (bus_addr == 4'(8 + c)) rd_mux = {res_valid, res_ovf[c], 6'b0, 24'(res_cnt[c])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // stop overrides go; either command preempts the normal sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      ARM:     if (ref_rise) state_nxt = GATE;
      GATE:    if (ref_rise && (gate_cnt_inc == gate_lim)) state_nxt = DONE;
      DONE:    state_nxt = cont ? GATE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (stop_cmd)    state_nxt = IDLE;
    else if (go_cmd) state_nxt = ARM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cont      <= 1'b0;
      done      <= 1'b0;
      gate_len  <= CNT_W'(1);
      gate_lim  <= CNT_W'(1);
      gate_cnt  <= '0;
      edge_ovf  <= '0;
      res_ovf   <= '0;
      res_valid <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        edge_cnt[c] <= '0;
        res_cnt[c]  <= '0;
      end
    end else begin
      if (wr_stb && (wr_addr == 4'h1)) gate_len <= wr_data[CNT_W-1:0];
      if (csr_wr) begin
        cont <= wr_data[29] & ~wr_data[30];
        if (wr_data[27]) done <= 1'b0;
      end

      case (state)
        ARM: begin
          gate_lim <= eff_len;
          gate_cnt <= '0;
          edge_ovf <= '0;
          for (int c = 0; c < N_CH; c++) edge_cnt[c] <= '0;
        end
        GATE: begin
          if (ref_rise) gate_cnt <= gate_cnt_inc;
          for (int c = 0; c < N_CH; c++) begin
            if (sig_rise[c]) begin
              if (edge_cnt[c] == {CNT_W{1'b1}}) edge_ovf[c] <= 1'b1;
              else                              edge_cnt[c] <= edge_cnt[c] + CNT_W'(1);
            end
          end
        end
        DONE: begin
          res_valid <= 1'b1;
          res_ovf   <= edge_ovf;
          done      <= 1'b1;
          gate_cnt  <= '0;
          edge_ovf  <= '0;
          // Edges in this cycle already belong to the next back-to-back gate
          for (int c = 0; c < N_CH; c++) begin
            res_cnt[c]  <= edge_cnt[c];
            edge_cnt[c] <= CNT_W'(sig_rise[c]);
          end
        end
        default: ;
      endcase

      if (go_cmd) begin
        done      <= 1'b0;
        res_valid <= 1'b0;
        res_ovf   <= '0;
        for (int c = 0; c < N_CH; c++) res_cnt[c] <= '0;
      end
    end
  end

`ifdef WB_FREQ_SCAN_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (csr_wr) irq_en <= wr_data[28];
      irq <= done & irq_en;
    end
  end

  assign irq_en_rd = irq_en;
`else
  assign irq_en_rd = 1'b0;
`endif

endmodule

// File: tb/tb_wb_freq_scan.sv
// Directed self-checking bench for wb_freq_scan; a 24-bit and an 8-bit instance share bus and stimulus.
// Define WB_FREQ_SCAN_IRQ_EN to also exercise the interrupt output.
module tb_wb_freq_scan;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] sig_in = '0;
  logic            ref_in = 1'b0;
  logic [3:0]      bus_addr = '0;
  logic [31:0]     bus_wdata = '0;
  logic            bus_cyc = 1'b0;
  logic            bus_we = 1'b0;
  logic [31:0]     bus_rdata, rdata8;
  logic            bus_ack, ack8;
`ifdef WB_FREQ_SCAN_IRQ_EN
  logic            irq, irq8;
`endif

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;
  int ref_per = 0;
  int sig_per [N_CH];
  int sig_off [N_CH];

  always #5 clk = ~clk;

  wb_freq_scan #(.N_CH(N_CH), .CNT_W(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ref_in(ref_in),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_cyc(bus_cyc), .bus_ack(bus_ack), .bus_we(bus_we)
`ifdef WB_FREQ_SCAN_IRQ_EN
    , .irq(irq)
`endif
  );

  wb_freq_scan #(.N_CH(N_CH), .CNT_W(8), .SYNC_STAGES(3)) dut8 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ref_in(ref_in),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata8),
    .bus_cyc(bus_cyc), .bus_ack(ack8), .bus_we(bus_we)
`ifdef WB_FREQ_SCAN_IRQ_EN
    , .irq(irq8)
`endif
  );

  // Periodic waveform generator; all edges derive from one cycle counter so phases are fixed
  initial begin
    for (int c = 0; c < N_CH; c++) begin
      sig_per[c] = 0;
      sig_off[c] = 0;
    end
    forever begin
      @(negedge clk);
      tb_cyc++;
      ref_in = (ref_per > 0) && ((tb_cyc % ref_per) < (ref_per / 2));
      for (int c = 0; c < N_CH; c++)
        sig_in[c] = (sig_per[c] > 0) && (((tb_cyc + sig_off[c]) % sig_per[c]) < (sig_per[c] / 2));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int rp, input int p0, input int o0, input int p1, input int p2);
    ref_per    = rp;
    sig_per[0] = p0;
    sig_off[0] = o0;
    sig_per[1] = p1;
    sig_per[2] = p2;
    sig_per[3] = 0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1; bus_cyc = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      got = bus_ack;
    end
    bus_cyc = 1'b0; bus_we = 1'b0;
    if (!got) checkOutput("write_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic bus_read(input logic [3:0] a, input bit sel8, output logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    bus_addr = a; bus_we = 1'b0; bus_cyc = 1'b1;
    d = 32'hDEAD_BEEF;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      got = sel8 ? ack8 : bus_ack;
    end
    if (got) d = sel8 ? rdata8 : bus_rdata;
    bus_cyc = 1'b0;
    if (!got) checkOutput("read_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input bit sel8,
                            input logic [31:0] mask, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, sel8, d);
    checkOutput(tag, d & mask, exp);
  endtask

  task automatic wait_csr(input string tag, input logic [31:0] mask, input logic [31:0] val);
    logic [31:0] d;
    bit hit = 0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      bus_read(4'h0, 1'b0, d);
      hit = ((d & mask) == val);
    end
    checkOutput(tag, {31'b0, hit}, 32'd1);
  endtask

  initial begin
    logic [31:0] r1, r2;
    applyStimulus(0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_ack", {31'b0, bus_ack}, 32'd0);
    checkOutput("reset_rdata", bus_rdata, 32'd0);
    read_check("reset_csr", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
    read_check("reset_gate_len", 4'h1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    read_check("reset_result0", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
    read_check("undef_addr", 4'h5, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
    read_check("result_beyond_nch", 4'hC, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);

    $display("[TB] basic single-shot measurement");
    applyStimulus(20, 4, 0, 0, 2);
    repeat (40) @(negedge clk);
    bus_write(4'h1, 32'd10);
    read_check("gate_len_rw", 4'h1, 1'b0, 32'hFFFF_FFFF, 32'd10);
    bus_write(4'h0, 32'h8000_0000);
    read_check("busy_after_go", 4'h0, 1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_csr("basic_idle", 32'h8000_0000, 32'h0);
    read_check("basic_result0", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h8000_0032);
    read_check("basic_result1", 4'h9, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
    read_check("basic_result2", 4'hA, 1'b0, 32'hFFFF_FFFF, 32'h8000_0064);
    read_check("basic_csr_done", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0800_0000);
    bus_write(4'h0, 32'h0800_0000);
    read_check("done_w1c", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);

    $display("[TB] GATE_LEN zero acts as one");
    bus_write(4'h1, 32'd0);
    read_check("gate_len_zero_rb", 4'h1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    bus_write(4'h0, 32'h8000_0000);
    wait_csr("gl0_idle", 32'h8000_0000, 32'h0);
    read_check("gl0_result0", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h8000_0005);

    $display("[TB] saturation on 8-bit instance");
    applyStimulus(20, 2, 0, 0, 0);
    repeat (20) @(negedge clk);
    bus_write(4'h1, 32'd40);
    bus_write(4'h0, 32'h8000_0000);
    wait_csr("sat_idle", 32'h8000_0000, 32'h0);
    read_check("sat_result0_cnt8", 4'h8, 1'b1, 32'hFFFF_FFFF, 32'hC000_00FF);
    read_check("sat_result0_cnt24", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h8000_0190);

    $display("[TB] continuous mode");
    applyStimulus(20, 4, 3, 0, 0);
    repeat (20) @(negedge clk);
    bus_write(4'h1, 32'd5);
    bus_write(4'h0, 32'hA000_0000);
    read_check("cont_csr_running", 4'h0, 1'b0, 32'hA000_0000, 32'hA000_0000);
    wait_csr("cont_done1", 32'h0800_0000, 32'h0800_0000);
    bus_read(4'h8, 1'b0, r1);
    checkOutput("cont_gate1", r1, 32'h8000_0019);
    bus_write(4'h0, 32'h2800_0000);
    wait_csr("cont_done2", 32'h0800_0000, 32'h0800_0000);
    bus_read(4'h8, 1'b0, r2);
    checkOutput("cont_gate2", r2, 32'h8000_0019);
    checkOutput("cont_gapfree_sum", 32'(r1[23:0]) + 32'(r2[23:0]), 32'd50);
    bus_write(4'h0, 32'h4000_0000);
    read_check("stop_csr", 4'h0, 1'b0, 32'hE700_0000, 32'h0000_0000);
    read_check("stop_keeps_result", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h8000_0019);

    $display("[TB] restart with go while busy");
    applyStimulus(20, 2, 0, 0, 0);
    repeat (20) @(negedge clk);
    bus_write(4'h1, 32'd10);
    bus_write(4'h0, 32'h8000_0000);
    read_check("go_clears_result", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
    repeat (60) @(negedge clk);
    applyStimulus(20, 4, 0, 0, 0);
    repeat (30) @(negedge clk);
    read_check("still_busy_before_rego", 4'h0, 1'b0, 32'h8000_0000, 32'h8000_0000);
    bus_write(4'h0, 32'h8000_0000);
    read_check("rego_valid_low", 4'h8, 1'b0, 32'h8000_0000, 32'h0000_0000);
    wait_csr("rego_idle", 32'h8000_0000, 32'h0);
    read_check("rego_result0", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h8000_0032);

    $display("[TB] reset during gate");
    bus_write(4'h0, 32'h8000_0000);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_check("rst_mid_csr", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
    read_check("rst_mid_gate_len", 4'h1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    read_check("rst_mid_result0", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
    bus_write(4'h0, 32'h8000_0000);
    wait_csr("post_rst_idle", 32'h8000_0000, 32'h0);
    read_check("post_rst_result0", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h8000_0005);
    read_check("post_rst_csr", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0800_0000);

    $display("[TB] stop and go together");
    bus_write(4'h0, 32'hC000_0000);
    read_check("stop_go_csr", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0800_0000);
    read_check("stop_go_result0", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'h8000_0005);

`ifdef WB_FREQ_SCAN_IRQ_EN
    $display("[TB] interrupt");
    bus_write(4'h0, 32'h1800_0000);
    read_check("irq_en_rw", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h1000_0000);
    checkOutput("irq_low_after_clear", {31'b0, irq}, 32'd0);
    bus_write(4'h0, 32'h9000_0000);
    wait_csr("irq_done", 32'h0800_0000, 32'h0800_0000);
    checkOutput("irq_high", {31'b0, irq}, 32'd1);
    bus_write(4'h0, 32'h1800_0000);
    repeat (2) @(negedge clk);
    checkOutput("irq_cleared", {31'b0, irq}, 32'd0);
`else
    $display("[TB] irq_en bit absent");
    bus_write(4'h0, 32'h1000_0000);
    read_check("irq_en_reads_zero", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h0800_0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
